// File: rtl/spi_pkg.sv
// spi_pkg: word width, bit-counter width, slave FSM states and the
// CPOL/CPHA decode shared by the SPI master and slave.
package spi_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_CNT_W  = 4;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_MAX = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  function automatic logic spi_cpol(input int mode);
    return ((mode == 32'sd2) || (mode == 32'sd3)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic spi_cpha(input int mode);
    return ((mode == 32'sd1) || (mode == 32'sd3)) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus history flop; rise/fall are
// flagged in the cycle after the synchronized level changes.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic hist_r;

  // synchronizer chain and one-cycle history of the synchronized level
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      hist_r <= 1'b0;
    end else begin
      s1_r   <= d;
      s2_r   <= s1_r;
      hist_r <= s2_r;
    end
  end

  assign q    = s2_r;
  assign rise = s2_r & ~hist_r;
  assign fall = ~s2_r & hist_r;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: 16-bit SPI peripheral, fully oversampled in the i_clk domain.
// Build macro SPI_SLAVE_ECHO_EN: underrun words echo the last received word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SPI_WORD_W-1:0] i_din,
  input  logic                  i_load,
  output logic                  o_tx_ready,
  output logic [SPI_WORD_W-1:0] o_dout,
  output logic                  o_rx_done,
  output logic                  o_tx_underrun,
  output logic                  o_frame_err,
  output logic                  o_busy,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  spi_state_e            state_r, state_nxt_s;
  logic [SPI_WORD_W-1:0] hold_r, hold_nxt_s;
  logic [SPI_WORD_W-1:0] tx_sr_r, tx_sr_nxt_s;
  logic [SPI_WORD_W-1:0] rx_sr_r, rx_sr_nxt_s;
  logic [SPI_WORD_W-1:0] dout_r, dout_nxt_s;
  logic [SPI_WORD_W-1:0] ws_word_s;
  logic [SPI_CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic hold_vld_r, hold_vld_nxt_s;
  logic miso_r, miso_nxt_s;
  logic busy_r;
  logic rx_done_r, rx_done_nxt_s;
  logic underrun_r, underrun_nxt_s;
  logic frame_err_r, frame_err_nxt_s;
  logic word_start_s;
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic lead_s, trail_s, sample_s, shift_s;
  logic unused_s;

  sync_edge_det u_sync_sclk (.i_clk(i_clk), .i_rst(i_rst), .d(i_sclk),
                             .q(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
  sync_edge_det u_sync_cs   (.i_clk(i_clk), .i_rst(i_rst), .d(i_cs_n),
                             .q(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
  sync_edge_det u_sync_mosi (.i_clk(i_clk), .i_rst(i_rst), .d(i_mosi),
                             .q(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));

  // synchronizer outputs this endpoint has no use for
  assign unused_s = ^{sclk_lvl_s, cs_lvl_s, mosi_rise_s, mosi_fall_s};

  assign lead_s   = CPOL ? sclk_fall_s : sclk_rise_s;
  assign trail_s  = CPOL ? sclk_rise_s : sclk_fall_s;
  assign sample_s = CPHA ? trail_s : lead_s;
  assign shift_s  = CPHA ? lead_s : trail_s;

  // next-state: load handshake, frame FSM, sample/shift and word start
  always_comb begin
    state_nxt_s     = state_r;
    hold_nxt_s      = hold_r;
    hold_vld_nxt_s  = hold_vld_r;
    tx_sr_nxt_s     = tx_sr_r;
    rx_sr_nxt_s     = rx_sr_r;
    dout_nxt_s      = dout_r;
    cnt_nxt_s       = cnt_r;
    miso_nxt_s      = miso_r;
    rx_done_nxt_s   = 1'b0;
    underrun_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
    word_start_s    = 1'b0;
    ws_word_s       = {SPI_WORD_W{1'b0}};

    if (i_load && !hold_vld_r) begin
      hold_nxt_s     = i_din;
      hold_vld_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = hold_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s  = ST_ACTIVE;
          word_start_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          state_nxt_s     = ST_IDLE;
          frame_err_nxt_s = (cnt_r != SPI_CNT_MAX);
        end else if (sample_s) begin
          rx_sr_nxt_s[cnt_r] = mosi_s;
          cnt_nxt_s          = cnt_r - 4'd1;
          if (cnt_r == 4'd0) begin
            dout_nxt_s    = {rx_sr_r[SPI_WORD_W-1:1], mosi_s};
            rx_done_nxt_s = 1'b1;
            word_start_s  = 1'b1;
          end else begin
            rx_done_nxt_s = 1'b0;
          end
        end else if (shift_s) begin
          // with CPHA=0 the word start already drove bit 15 of the next word
          if (!(!CPHA && (cnt_r == SPI_CNT_MAX))) begin
            miso_nxt_s  = CPHA ? tx_sr_r[SPI_WORD_W-1] : tx_sr_r[SPI_WORD_W-2];
            tx_sr_nxt_s = {tx_sr_r[SPI_WORD_W-2:0], 1'b0};
          end else begin
            miso_nxt_s = miso_r;
          end
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    // word start sees the holding state from before this cycle's load
    if (word_start_s) begin
      if (hold_vld_r) begin
        ws_word_s      = hold_r;
        hold_vld_nxt_s = 1'b0;
      end else begin
`ifdef SPI_SLAVE_ECHO_EN
        ws_word_s      = dout_nxt_s;
`else
        ws_word_s      = {SPI_WORD_W{1'b0}};
`endif
        underrun_nxt_s = 1'b1;
      end
      tx_sr_nxt_s = ws_word_s;
      cnt_nxt_s   = SPI_CNT_MAX;
      miso_nxt_s  = CPHA ? miso_r : ws_word_s[SPI_WORD_W-1];
    end else begin
      ws_word_s = {SPI_WORD_W{1'b0}};
    end
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= ST_IDLE;
      hold_r      <= {SPI_WORD_W{1'b0}};
      hold_vld_r  <= 1'b0;
      tx_sr_r     <= {SPI_WORD_W{1'b0}};
      rx_sr_r     <= {SPI_WORD_W{1'b0}};
      dout_r      <= {SPI_WORD_W{1'b0}};
      cnt_r       <= SPI_CNT_MAX;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      rx_done_r   <= 1'b0;
      underrun_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_vld_r  <= hold_vld_nxt_s;
      tx_sr_r     <= tx_sr_nxt_s;
      rx_sr_r     <= rx_sr_nxt_s;
      dout_r      <= dout_nxt_s;
      cnt_r       <= cnt_nxt_s;
      miso_r      <= miso_nxt_s;
      busy_r      <= (state_nxt_s == ST_ACTIVE);
      rx_done_r   <= rx_done_nxt_s;
      underrun_r  <= underrun_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  assign o_tx_ready    = ~hold_vld_r;
  assign o_dout        = dout_r;
  assign o_rx_done     = rx_done_r;
  assign o_tx_underrun = underrun_r;
  assign o_frame_err   = frame_err_r;
  assign o_busy        = busy_r;
  assign o_miso        = miso_r;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: one slave per SPI mode driven by a behavioural master;
// received words are checked by a scoreboard monitor on o_rx_done.
`timescale 1ns/1ps
module tb_spi_slave;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic [3:0]       sclk = 4'b1100;
  logic [3:0]       cs_n = 4'b1111;
  logic [3:0]       mosi = 4'b0000;
  logic [3:0]       load = 4'b0000;
  logic [3:0][15:0] din  = '0;
  logic [3:0][15:0] dout;
  logic [3:0] tx_ready, rx_done, underrun, frame_err, busy, miso;

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_din(din[g]), .i_load(load[g]),
      .o_tx_ready(tx_ready[g]), .o_dout(dout[g]), .o_rx_done(rx_done[g]),
      .o_tx_underrun(underrun[g]), .o_frame_err(frame_err[g]), .o_busy(busy[g]),
      .i_sclk(sclk[g]), .i_cs_n(cs_n[g]), .i_mosi(mosi[g]), .o_miso(miso[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] dout_q[4][$];
  int rx_cnt[4]   = '{default: 0};
  int ur_cnt[4]   = '{default: 0};
  int ferr_cnt[4] = '{default: 0};
  logic [15:0] mtx[2];
  logic [15:0] mexp[2];
  logic [15:0] mrx[2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops expected words on o_rx_done, counts pulses
  always @(negedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        if (rx_done[k]) begin
          rx_cnt[k]++;
          check("rx_expected", 16'(dout_q[k].size() > 0), 16'd1);
          if (dout_q[k].size() > 0) check("rx_word", dout[k], dout_q[k].pop_front());
        end
        if (underrun[k]) ur_cnt[k]++;
        if (frame_err[k]) ferr_cnt[k]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic half();
    repeat (4) @(negedge i_clk);
  endtask

  task automatic do_load(input int m, input logic [15:0] w);
    @(negedge i_clk);
    din[m]  = w;
    load[m] = 1'b1;
    @(negedge i_clk);
    load[m] = 1'b0;
  endtask

  // master: CLKS_PER_HALF_BIT=4, sends mtx, collects MISO into mrx
  task automatic frame(input int m, input int nbits, input bit drop_cs);
    bit cpol, cpha;
    logic [15:0] w;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    for (int i = 0; i < nbits / 16; i++) dout_q[m].push_back(mtx[i]);
    @(negedge i_clk);
    cs_n[m] = 1'b0;
    w = mtx[0];
    if (!cpha) mosi[m] = w[15];
    half();
    check("busy_in_frame", 16'(busy[m]), 16'd1);
    for (int b = 0; b < nbits; b++) begin
      w = mtx[b / 16];
      if (!cpha) begin
        sclk[m] = ~cpol;
        mrx[b / 16][15 - (b % 16)] = miso[m];
        half();
        sclk[m] = cpol;
        if (b + 1 < nbits) begin
          w = mtx[(b + 1) / 16];
          mosi[m] = w[15 - ((b + 1) % 16)];
        end
        half();
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = w[15 - (b % 16)];
        half();
        sclk[m] = cpol;
        mrx[b / 16][15 - (b % 16)] = miso[m];
        half();
      end
    end
    if (drop_cs) begin
      cs_n[m] = 1'b1;
      repeat (8) @(negedge i_clk);
    end
    for (int i = 0; i < nbits / 16; i++) check("miso_word", mrx[i], mexp[i]);
  endtask

  int ur0, rx0, fe0;

  initial begin
    repeat (4) @(negedge i_clk);
    check("rst_dout", dout[0], 16'h0000);
    check("rst_pulses_busy_miso", 16'({rx_done[0], underrun[0], frame_err[0], busy[0], miso[0]}), 16'h0000);
    check("rst_tx_ready", 16'(tx_ready), 16'h000F);
    i_rst = 1'b1;
    repeat (8) @(negedge i_clk);

    // mode 0 basic word
    do_load(0, 16'hA5C3);
    check("load_ready_low", 16'(tx_ready[0]), 16'd0);
    rx0 = rx_cnt[0];
    mtx[0] = 16'h1234; mexp[0] = 16'hA5C3;
    frame(0, 16, 1'b1);
    check("mode0_rx_pulses", 16'(rx_cnt[0] - rx0), 16'd1);
    check("mode0_dout", dout[0], 16'h1234);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      do_load(m, 16'h8001);
      mtx[0] = 16'hFFFE; mexp[0] = 16'h8001;
      frame(m, 16, 1'b1);
      check("modeN_dout", dout[m], 16'hFFFE);
    end

    // two-word frame, second word underruns; third word loaded during word 2
    do_load(0, 16'hBEEF);
    ur0 = ur_cnt[0]; fe0 = ferr_cnt[0];
    mtx[0] = 16'hCAFE; mtx[1] = 16'h5678;
    mexp[0] = 16'hBEEF;
`ifdef SPI_SLAVE_ECHO_EN
    mexp[1] = 16'hCAFE;
`else
    mexp[1] = 16'h0000;
`endif
    fork
      frame(0, 32, 1'b1);
      begin
        repeat (150) @(negedge i_clk);
        do_load(0, 16'hF00D);
      end
    join
    check("two_word_underruns", 16'(ur_cnt[0] - ur0), 16'd1);
    check("two_word_no_ferr", 16'(ferr_cnt[0] - fe0), 16'd0);

    // CS dropped after 7 bits
    do_load(0, 16'h7777);
    rx0 = rx_cnt[0]; fe0 = ferr_cnt[0];
    mtx[0] = 16'h3333;
    frame(0, 7, 1'b1);
    check("abort_ferr", 16'(ferr_cnt[0] - fe0), 16'd1);
    check("abort_no_rx", 16'(rx_cnt[0] - rx0), 16'd0);
    check("abort_dout_kept", dout[0], 16'h5678);
    do_load(0, 16'h1357);
    mtx[0] = 16'h2468; mexp[0] = 16'h1357;
    frame(0, 16, 1'b1);

    // second load while full is dropped
    do_load(0, 16'h1111);
    do_load(0, 16'h2222);
    check("second_load_ready", 16'(tx_ready[0]), 16'd0);
    mtx[0] = 16'h0F00; mexp[0] = 16'h1111;
    frame(0, 16, 1'b1);
    mtx[0] = 16'h00F0;
`ifdef SPI_SLAVE_ECHO_EN
    mexp[0] = 16'h0F00;
`else
    mexp[0] = 16'h0000;
`endif
    frame(0, 16, 1'b1);

    // reset mid-word
    do_load(0, 16'h5555);
    mtx[0] = 16'h6666;
    frame(0, 5, 1'b0);
    do_load(0, 16'h9999);
    check("pre_rst_ready", 16'(tx_ready[0]), 16'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("midrst_dout", dout[0], 16'h0000);
    check("midrst_busy_miso", 16'({busy[0], miso[0], rx_done[0], underrun[0], frame_err[0]}), 16'h0000);
    check("midrst_ready", 16'(tx_ready[0]), 16'd1);
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (8) @(negedge i_clk);
    do_load(0, 16'h0F0F);
    mtx[0] = 16'h3C3C; mexp[0] = 16'h0F0F;
    frame(0, 16, 1'b1);
    check("post_rst_dout", dout[0], 16'h3C3C);

    repeat (10) @(negedge i_clk);
    for (int k = 0; k < 4; k++) check("rx_outstanding", 16'(dout_q[k].size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
